// File: rtl/fault_recovery_ctrl_if.sv
// Fault recovery controller bus: fault detector inputs plus CPU pipeline control outputs.
// master = detector/CPU side driving faults and handshakes, slave = the controller.
interface fault_recovery_ctrl_if #(
  parameter int N_SRC     = 4,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 8
);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [N_SRC-1:0] fault_vec;
  logic [N_SRC-1:0] critical_mask;
  logic             recovery_done;
  logic             clear_halt;

  logic             freeze_cpu;
  logic             recover_cpu;
  logic             rollback_req;
  logic             resume_cpu;
  logic             halt_cpu;
  logic [N_SRC-1:0] fault_src;
  logic [RW-1:0]    retry_cnt;
  logic [CNT_W-1:0] fault_count;
  logic [2:0]       state;

  modport master (
    output fault_vec, critical_mask, recovery_done, clear_halt,
    input  freeze_cpu, recover_cpu, rollback_req, resume_cpu, halt_cpu,
    input  fault_src, retry_cnt, fault_count, state
  );

  modport slave (
    input  fault_vec, critical_mask, recovery_done, clear_halt,
    output freeze_cpu, recover_cpu, rollback_req, resume_cpu, halt_cpu,
    output fault_src, retry_cnt, fault_count, state
  );
endinterface

// File: rtl/fault_recovery_ctrl.sv
// Multi-source fault recovery sequencer: NORMAL -> FREEZE -> RECOVER -> RESUME,
// with recovery timeout, bounded retries and escalation to a sticky HALT.
// All outputs are a Moore decode of registered state, so no input reaches an output
// combinationally.
module fault_recovery_ctrl #(
  parameter int N_SRC      = 4,
  parameter int FREEZE_CYC = 2,
  parameter int TIMEOUT    = 16,
  parameter int MAX_RETRY  = 2,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fault_recovery_ctrl_if.slave  bus
);

  localparam int RW   = (MAX_RETRY > 0)  ? $clog2(MAX_RETRY + 1) : 1;
  localparam int FT_W = (FREEZE_CYC > 1) ? $clog2(FREEZE_CYC)    : 1;
  localparam int TO_W = (TIMEOUT > 1)    ? $clog2(TIMEOUT)       : 1;

  typedef enum logic [2:0] {
    S_NORMAL  = 3'd0,
    S_FREEZE  = 3'd1,
    S_RECOVER = 3'd2,
    S_RESUME  = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t           r_state;
  logic [N_SRC-1:0] r_src;
  logic [N_SRC-1:0] r_pend;
  logic             r_crit;
  logic [RW-1:0]    r_retry;
  logic [CNT_W-1:0] r_count;
  logic [FT_W-1:0]  r_ftmr;
  logic [TO_W-1:0]  r_rtmr;

  logic [N_SRC-1:0] w_chain_vec;
  logic             w_fault_any;
  logic             w_fault_crit;
  logic [CNT_W-1:0] w_count_inc;

  assign w_chain_vec  = r_pend | bus.fault_vec;
  assign w_fault_any  = |bus.fault_vec;
  assign w_fault_crit = |(bus.fault_vec & bus.critical_mask);
  assign w_count_inc  = (r_count == '1) ? r_count : r_count + CNT_W'(1);

  // Episode sequencer: state, timers, fault capture, retry and episode counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_NORMAL;
      r_src   <= '0;
      r_pend  <= '0;
      r_crit  <= 1'b0;
      r_retry <= '0;
      r_count <= '0;
      r_ftmr  <= '0;
      r_rtmr  <= '0;
    end else begin
      case (r_state)
        S_NORMAL: begin
          if (w_fault_any) begin
            r_state <= S_FREEZE;
            r_src   <= bus.fault_vec;
            r_crit  <= w_fault_crit;
            r_retry <= '0;
            r_count <= w_count_inc;
            r_ftmr  <= FT_W'(FREEZE_CYC - 1);
          end
        end
        S_FREEZE: begin
          r_src  <= r_src | bus.fault_vec;
          r_pend <= r_pend | bus.fault_vec;
          r_crit <= r_crit | w_fault_crit;
          if (r_ftmr == '0) begin
            r_state <= S_RECOVER;
            r_rtmr  <= TO_W'(TIMEOUT - 1);
          end else begin
            r_ftmr <= r_ftmr - FT_W'(1);
          end
        end
        S_RECOVER: begin
          r_src  <= r_src | bus.fault_vec;
          r_pend <= r_pend | bus.fault_vec;
          r_crit <= r_crit | w_fault_crit;
          // Completion takes priority over a timeout expiring in the same cycle.
          if (bus.recovery_done) begin
            r_state <= S_RESUME;
          end else if (r_rtmr == '0) begin
            if (r_retry == RW'(MAX_RETRY)) begin
              r_state <= S_HALT;
            end else begin
              r_state <= S_FREEZE;
              r_retry <= r_retry + RW'(1);
              r_ftmr  <= FT_W'(FREEZE_CYC - 1);
            end
          end else begin
            r_rtmr <= r_rtmr - TO_W'(1);
          end
        end
        S_RESUME: begin
          r_pend <= '0;
          // Faults that arrived during the episode (or right now) start a new one
          // immediately instead of returning to NORMAL.
          if (|w_chain_vec) begin
            r_state <= S_FREEZE;
            r_src   <= w_chain_vec;
            r_crit  <= |(w_chain_vec & bus.critical_mask);
            r_retry <= '0;
            r_count <= w_count_inc;
            r_ftmr  <= FT_W'(FREEZE_CYC - 1);
          end else begin
            r_state <= S_NORMAL;
          end
        end
        S_HALT: begin
          // Pending faults belong to the abandoned episode and are dropped on release.
          if (bus.clear_halt) begin
            r_state <= S_NORMAL;
            r_src   <= '0;
            r_pend  <= '0;
            r_retry <= '0;
            r_crit  <= 1'b0;
          end
        end
        default: r_state <= S_NORMAL;
      endcase
    end
  end

  assign bus.freeze_cpu   = (r_state == S_FREEZE) || (r_state == S_HALT);
  assign bus.recover_cpu  = (r_state == S_RECOVER);
  assign bus.resume_cpu   = (r_state == S_RESUME);
  assign bus.halt_cpu     = (r_state == S_HALT);
  assign bus.rollback_req = (r_state == S_RECOVER) && r_crit;
  assign bus.fault_src    = r_src;
  assign bus.retry_cnt    = r_retry;
  assign bus.fault_count  = r_count;
  assign bus.state        = r_state;

endmodule

// File: tb/tb_fault_recovery_ctrl.sv
// Scoreboard bench for fault_recovery_ctrl: expected per-cycle outputs are queued as
// stimulus is applied and compared on the falling edge when the DUT presents them.
module tb_fault_recovery_ctrl;

  localparam logic [2:0] NRM = 3'd0;
  localparam logic [2:0] FRZ = 3'd1;
  localparam logic [2:0] REC = 3'd2;
  localparam logic [2:0] RSM = 3'd3;
  localparam logic [2:0] HLT = 3'd4;

  typedef struct {
    logic [2:0] st;
    logic [3:0] src;
    logic [1:0] rt;
    logic [7:0] cnt;
    logic       rb;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;
  exp_t q[$];
  exp_t cur;

  always #5 clk = ~clk;

  fault_recovery_ctrl_if #(.N_SRC(4), .MAX_RETRY(2), .CNT_W(8)) bus ();

  fault_recovery_ctrl #(
    .N_SRC(4), .FREEZE_CYC(2), .TIMEOUT(16), .MAX_RETRY(2), .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".state"},   32'(bus.state), 0);
    check({tag, ".freeze"},  32'(bus.freeze_cpu), 0);
    check({tag, ".recover"}, 32'(bus.recover_cpu), 0);
    check({tag, ".resume"},  32'(bus.resume_cpu), 0);
    check({tag, ".halt"},    32'(bus.halt_cpu), 0);
    check({tag, ".rollback"},32'(bus.rollback_req), 0);
    check({tag, ".src"},     32'(bus.fault_src), 0);
    check({tag, ".retry"},   32'(bus.retry_cnt), 0);
    check({tag, ".count"},   32'(bus.fault_count), 0);
  endtask

  // Wait for the next rising edge, then queue what the outputs must show for this cycle.
  task automatic step(input logic [2:0] st, input logic [3:0] src, input logic [1:0] rt,
                      input logic [7:0] cnt, input logic rb);
    exp_t e;
    @(posedge clk);
    #1;
    e.st = st; e.src = src; e.rt = rt; e.cnt = cnt; e.rb = rb;
    q.push_back(e);
  endtask

  task automatic steps(input int n, input logic [2:0] st, input logic [3:0] src,
                       input logic [1:0] rt, input logic [7:0] cnt, input logic rb);
    for (int i = 0; i < n; i++) step(st, src, rt, cnt, rb);
  endtask

  always begin
    @(negedge clk);
    if (q.size() > 0) begin
      cur = q.pop_front();
      check("state",    32'(bus.state), 32'(cur.st));
      check("freeze",   32'(bus.freeze_cpu), 32'(cur.st == FRZ || cur.st == HLT));
      check("recover",  32'(bus.recover_cpu), 32'(cur.st == REC));
      check("resume",   32'(bus.resume_cpu), 32'(cur.st == RSM));
      check("halt",     32'(bus.halt_cpu), 32'(cur.st == HLT));
      check("rollback", 32'(bus.rollback_req), 32'(cur.rb));
      check("src",      32'(bus.fault_src), 32'(cur.src));
      check("retry",    32'(bus.retry_cnt), 32'(cur.rt));
      check("count",    32'(bus.fault_count), 32'(cur.cnt));
    end
  end

  initial begin
    bus.fault_vec     = '0;
    bus.critical_mask = '0;
    bus.recovery_done = 1'b0;
    bus.clear_halt    = 1'b0;
    #2;
    check_all_zero("rst_hold");
    #10 reset_n = 1'b1;
    step(NRM, 4'b0000, 0, 0, 0);

    // 1: minor episode, done in the 5th RECOVER cycle
    bus.fault_vec = 4'b0010;
    step(FRZ, 4'b0010, 0, 1, 0);
    bus.fault_vec = '0;
    step(FRZ, 4'b0010, 0, 1, 0);
    steps(5, REC, 4'b0010, 0, 1, 0);
    bus.recovery_done = 1'b1;
    step(RSM, 4'b0010, 0, 1, 0);
    bus.recovery_done = 1'b0;
    step(NRM, 4'b0010, 0, 1, 0);
    // stray done / clear_halt in NORMAL do nothing
    bus.recovery_done = 1'b1;
    step(NRM, 4'b0010, 0, 1, 0);
    bus.recovery_done = 1'b0;
    bus.clear_halt = 1'b1;
    step(NRM, 4'b0010, 0, 1, 0);
    bus.clear_halt = 1'b0;

    // 2: critical fault arriving mid-recovery, then chained episode from pend
    bus.critical_mask = 4'b1000;
    bus.fault_vec = 4'b0001;
    step(FRZ, 4'b0001, 0, 2, 0);
    bus.fault_vec = '0;
    step(FRZ, 4'b0001, 0, 2, 0);
    step(REC, 4'b0001, 0, 2, 0);
    bus.fault_vec = 4'b1000;
    step(REC, 4'b1001, 0, 2, 1);
    bus.fault_vec = '0;
    bus.recovery_done = 1'b1;
    step(RSM, 4'b1001, 0, 2, 0);
    bus.recovery_done = 1'b0;
    steps(2, FRZ, 4'b1000, 0, 3, 0);
    step(REC, 4'b1000, 0, 3, 1);
    bus.recovery_done = 1'b1;
    step(RSM, 4'b1000, 0, 3, 0);
    bus.recovery_done = 1'b0;
    step(NRM, 4'b1000, 0, 3, 0);
    bus.critical_mask = '0;

    // 3: timeout escalation, three rounds then HALT 54 cycles after FREEZE entry
    bus.fault_vec = 4'b0100;
    step(FRZ, 4'b0100, 0, 4, 0);
    bus.fault_vec = '0;
    step(FRZ, 4'b0100, 0, 4, 0);
    steps(16, REC, 4'b0100, 0, 4, 0);
    steps(2,  FRZ, 4'b0100, 1, 4, 0);
    steps(16, REC, 4'b0100, 1, 4, 0);
    steps(2,  FRZ, 4'b0100, 2, 4, 0);
    steps(16, REC, 4'b0100, 2, 4, 0);
    step(HLT, 4'b0100, 2, 4, 0);
    bus.fault_vec = 4'b1111;
    bus.recovery_done = 1'b1;
    steps(3, HLT, 4'b0100, 2, 4, 0);
    bus.fault_vec = '0;
    bus.recovery_done = 1'b0;
    bus.clear_halt = 1'b1;
    step(NRM, 4'b0000, 0, 4, 0);
    bus.clear_halt = 1'b0;
    step(NRM, 4'b0000, 0, 4, 0);

    // 4: done coincides with the last RECOVER cycle (timeout) -> done wins
    bus.fault_vec = 4'b0001;
    step(FRZ, 4'b0001, 0, 5, 0);
    bus.fault_vec = '0;
    step(FRZ, 4'b0001, 0, 5, 0);
    steps(16, REC, 4'b0001, 0, 5, 0);
    bus.recovery_done = 1'b1;
    step(RSM, 4'b0001, 0, 5, 0);
    bus.recovery_done = 1'b0;
    step(NRM, 4'b0001, 0, 5, 0);

    // 5: pending fault during RECOVER chains straight into a new FREEZE
    bus.fault_vec = 4'b0001;
    step(FRZ, 4'b0001, 0, 6, 0);
    bus.fault_vec = '0;
    step(FRZ, 4'b0001, 0, 6, 0);
    step(REC, 4'b0001, 0, 6, 0);
    bus.fault_vec = 4'b0100;
    step(REC, 4'b0101, 0, 6, 0);
    bus.fault_vec = '0;
    bus.recovery_done = 1'b1;
    step(RSM, 4'b0101, 0, 6, 0);
    bus.recovery_done = 1'b0;
    steps(2, FRZ, 4'b0100, 0, 7, 0);
    step(REC, 4'b0100, 0, 7, 0);
    bus.recovery_done = 1'b1;
    step(RSM, 4'b0100, 0, 7, 0);
    bus.recovery_done = 1'b0;
    step(NRM, 4'b0100, 0, 7, 0);

    // 6: asynchronous reset in the middle of RECOVER
    bus.fault_vec = 4'b0010;
    step(FRZ, 4'b0010, 0, 8, 0);
    bus.fault_vec = '0;
    step(FRZ, 4'b0010, 0, 8, 0);
    steps(2, REC, 4'b0010, 0, 8, 0);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    #1 reset_n = 1'b1;
    step(NRM, 4'b0000, 0, 0, 0);
    step(NRM, 4'b0000, 0, 0, 0);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fault_recovery_ctrl.md
Name: fault_recovery_ctrl

Overview:
- Multi-source fault recovery controller that sits between the fault detectors and CPU pipeline control, in the fault-handling path of the fault-tolerant core.
- Generalises the single freeze/recover/resume sequencer to N fault sources with per-source criticality, a programmable freeze window, and a recovery timeout with bounded retries.
- Escalates to a sticky HALT when retries are exhausted, and exposes fault capture and episode statistics.

Parameters:
- N_SRC, 4, number of fault source inputs.
- FREEZE_CYC, 2, cycles spent in FREEZE before RECOVER (>=1).
- TIMEOUT, 16, RECOVER cycles allowed before a retry is declared (>=1).
- MAX_RETRY, 2, retries permitted before escalation to HALT (>=0).
- CNT_W, 8, width of the saturating fault episode counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- fault_vec  in  N_SRC  per-source fault flags, level or single-cycle pulse.
- critical_mask  in  N_SRC  1 = corresponding source is critical, quasi-static.
- recovery_done  in  1  recovery engine completion pulse.
- clear_halt  in  1  software/debug release from HALT.
- freeze_cpu  out  1  stall pipeline.
- recover_cpu  out  1  recovery in progress.
- rollback_req  out  1  recovery must restore checkpoint (critical episode).
- resume_cpu  out  1  single-cycle restart strobe.
- halt_cpu  out  1  permanent stop until cleared.
- fault_src  out  N_SRC  sticky sources captured for the current episode.
- retry_cnt  out  $clog2(MAX_RETRY+1)  retries consumed in the current episode.
- fault_count  out  CNT_W  saturating count of episodes since reset.
- state  out  3  encoded state: NORMAL=0, FREEZE=1, RECOVER=2, RESUME=3, HALT=4.

Behaviour:
- Reset: reset_n low asynchronously forces state=NORMAL and clears every internal register. All outputs are 0 while reset is held and on the first cycle after release.
- Output decode: all outputs are decoded from registered state only (Moore).
  - freeze_cpu = FREEZE or HALT.
  - recover_cpu = RECOVER.
  - resume_cpu = RESUME.
  - halt_cpu = HALT.
  - rollback_req = RECOVER and crit_latched.
- Internal registers: crit_latched, pend (N_SRC), freeze timer, recovery timer.

State transitions:
- NORMAL, when |fault_vec:
  - go to FREEZE;
  - fault_src <= fault_vec;
  - crit_latched <= |(fault_vec & critical_mask);
  - retry_cnt <= 0;
  - fault_count++, saturating at all-ones;
  - freeze timer loads FREEZE_CYC-1.
- FREEZE: timer decrements each cycle. At 0, go to RECOVER and load the recovery timer with TIMEOUT-1. FREEZE lasts exactly FREEZE_CYC cycles.
- RECOVER:
  - recovery_done goes to RESUME.
  - Otherwise the timer decrements. On timer==0 with no done:
    - if retry_cnt==MAX_RETRY, go to HALT;
    - else retry_cnt++, go to FREEZE, reload the freeze timer.
  - If recovery_done and timeout occur in the same cycle, done wins.
- RESUME: one cycle only.
  - If pend!=0 or |fault_vec: go to FREEZE as a new episode.
    - fault_src <= pend | fault_vec;
    - crit_latched recomputed from that vector;
    - retry_cnt <= 0;
    - fault_count++;
    - pend <= 0.
  - Else go to NORMAL and clear pend.
- HALT: sticky, and fault_vec is ignored. clear_halt goes to NORMAL and clears fault_src, retry_cnt and crit_latched. fault_count is kept.
- Fault accumulation: in FREEZE and RECOVER, fault_vec bits are ORed into fault_src and pend. crit_latched is ORed with |(fault_vec & critical_mask). A critical fault arriving mid-recovery therefore asserts rollback_req from the next cycle.
- recovery_done outside RECOVER is ignored. clear_halt outside HALT is ignored.
- The encoding is illegal for state 5-7, which go to NORMAL on the next cycle.
- No combinational path exists from any input to any output.

Test Plan:
Defaults N_SRC=4, FREEZE_CYC=2, TIMEOUT=16, MAX_RETRY=2.
1. Minor episode:
   - Stimulus: fault_vec=4'b0010 pulse with mask=0, recovery_done at the 5th RECOVER cycle.
   - Response: freeze_cpu high 2 cycles, recover_cpu 5 cycles with rollback_req=0, resume_cpu 1 cycle, fault_src=0010, fault_count=1, then back to NORMAL.
2. Critical late arrival:
   - Stimulus: minor fault on bit0, then fault_vec=4'b1000 with mask=4'b1000 during RECOVER.
   - Response: rollback_req rises the next cycle, fault_src=1001.
3. Timeout escalation:
   - Stimulus: a fault with recovery_done never asserted.
   - Response: 3 FREEZE/RECOVER rounds (retry_cnt 0→1→2), HALT exactly 3*(2+16) cycles after entering FREEZE, halt_cpu=freeze_cpu=1. Faults in HALT have no effect.
   - Then pulse clear_halt: NORMAL, retry_cnt=0, fault_src=0, fault_count still 1.
4. Done/timeout collision: recovery_done asserted on the 16th RECOVER cycle → RESUME, retry_cnt unchanged at 0.
5. Pending fault chaining: fault pulse on bit2 during RECOVER, then recovery_done → RESUME for 1 cycle, then directly FREEZE, fault_src=0100, fault_count=2.
6. Reset mid-RECOVER: deassert reset_n asynchronously → all outputs 0 immediately, and after release state=NORMAL, fault_count=0.
